// File: rtl/card_judge_multi.sv
// Round judge: accumulates per-player hand scores from a serial card stream
// and issues a one-cycle verdict (winner, bust mask, best score, illegal flag).
module card_judge_multi #(
    parameter int NUM_PLAYERS      = 2,
    parameter int CARDS_PER_PLAYER = 5,
    parameter int TARGET           = 21,
    parameter int ACE_HIGH         = 0,
    localparam int SW = $clog2(11*CARDS_PER_PLAYER+1),
    localparam int WW = $clog2(NUM_PLAYERS+1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [3:0]             card,
    output logic                   out_valid,
    output logic [WW-1:0]          winner,
    output logic [NUM_PLAYERS-1:0] bust,
    output logic [SW-1:0]          score_max,
    output logic                   err
);

    localparam int CNW = (CARDS_PER_PLAYER > 1) ? $clog2(CARDS_PER_PLAYER) : 1;
    localparam int PW  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int CW  = $clog2(CARDS_PER_PLAYER+1);
    localparam logic [31:0] TGT = 32'(TARGET);

    typedef enum logic [1:0] {IDLE, COLLECT, JUDGE, OUT} state_t;

    state_t                 state_q;
    logic [CNW-1:0]         card_q;
    logic [PW-1:0]          plr_q;
    logic [SW-1:0]          sum_q  [NUM_PLAYERS];
    logic [CW-1:0]          soft_q [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] bust_q;
    logic                   err_q;

    logic [WW-1:0]          res_win_q;
    logic [NUM_PLAYERS-1:0] res_bust_q;
    logic [SW-1:0]          res_score_q;
    logic                   res_err_q;

    logic                   accept;
    logic                   last_card;
    logic                   legal;
    logic [31:0]            val;
    logic [31:0]            sum_d;
    logic [CW-1:0]          soft_d;
    logic [SW-1:0]          j_max;
    logic [WW-1:0]          j_cnt;
    logic [WW-1:0]          j_win;

    always_comb begin
        accept    = in_valid && (state_q != JUDGE);
        last_card = accept && (card_q == CNW'(CARDS_PER_PLAYER-1))
                           && (plr_q == PW'(NUM_PLAYERS-1));
    end

    // Score update for the player currently being dealt to; a soft ace is
    // demoted from 11 to 1 at most once per card.
    always_comb begin
        legal = (card != 4'd0) && (card <= 4'd13);
        val   = 32'(card);
        if (!legal)
            val = '0;
        else if (card >= 4'd10)
            val = 32'd10;
        else if (card == 4'd1 && ACE_HIGH != 0)
            val = 32'd11;
        sum_d  = 32'(sum_q[plr_q]) + val;
        soft_d = soft_q[plr_q];
        if (ACE_HIGH != 0 && card == 4'd1)
            soft_d = soft_d + CW'(1);
        if (ACE_HIGH != 0 && sum_d > TGT && soft_d != '0) begin
            sum_d  = sum_d - 32'd10;
            soft_d = soft_d - CW'(1);
        end
    end

    always_comb begin
        j_max = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++)
            if (!bust_q[i] && sum_q[i] > j_max)
                j_max = sum_q[i];
        j_cnt = '0;
        j_win = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++)
            if (!bust_q[i] && sum_q[i] == j_max) begin
                j_cnt = j_cnt + WW'(1);
                j_win = WW'(i + 1);
            end
        if (j_cnt != WW'(1))
            j_win = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            card_q      <= '0;
            plr_q       <= '0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                sum_q[i]  <= '0;
                soft_q[i] <= '0;
            end
            bust_q      <= '0;
            err_q       <= 1'b0;
            res_win_q   <= '0;
            res_bust_q  <= '0;
            res_score_q <= '0;
            res_err_q   <= 1'b0;
            out_valid   <= 1'b0;
            winner      <= '0;
            bust        <= '0;
            score_max   <= '0;
            err         <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            winner    <= '0;
            bust      <= '0;
            score_max <= '0;
            err       <= 1'b0;

            case (state_q)
                IDLE:    if (accept) state_q <= COLLECT;
                COLLECT: if (last_card) state_q <= JUDGE;
                JUDGE:   state_q <= OUT;
                OUT:     state_q <= accept ? COLLECT : IDLE;
                default: state_q <= IDLE;
            endcase

            // Verdict is captured while leaving JUDGE so the round state can
            // be cleared on OUT entry and an OUT-cycle card starts clean.
            if (state_q == JUDGE) begin
                res_win_q   <= j_win;
                res_bust_q  <= bust_q;
                res_score_q <= j_max;
                res_err_q   <= err_q;
                for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                    sum_q[i]  <= '0;
                    soft_q[i] <= '0;
                end
                bust_q <= '0;
                err_q  <= 1'b0;
            end

            if (state_q == OUT) begin
                out_valid <= 1'b1;
                winner    <= res_win_q;
                bust      <= res_bust_q;
                score_max <= res_score_q;
                err       <= res_err_q;
            end

            if (accept) begin
                sum_q[plr_q]  <= SW'(sum_d);
                soft_q[plr_q] <= soft_d;
                bust_q[plr_q] <= bust_q[plr_q] | (sum_d > TGT);
                if (!legal)
                    err_q <= 1'b1;
                if (card_q == CNW'(CARDS_PER_PLAYER-1)) begin
                    card_q <= '0;
                    plr_q  <= (plr_q == PW'(NUM_PLAYERS-1)) ? '0 : plr_q + PW'(1);
                end else begin
                    card_q <= card_q + CNW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_card_judge_multi.sv
// Directed bench: two 2-player judges (ace low / ace high) share one card
// stream; a 4-player judge exercises mid-round reset and 3-way scoring.
module tb_card_judge_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv01 = 1'b0;
    logic       iv2 = 1'b0;
    logic [3:0] card = 4'd0;

    logic       ov0, e0, ov1, e1, ov2, e2;
    logic [1:0] w0, b0, w1, b1;
    logic [2:0] w2;
    logic [3:0] b2;
    logic [5:0] s0, s1, s2;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    card_judge_multi #(.ACE_HIGH(0)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv01), .card(card),
        .out_valid(ov0), .winner(w0), .bust(b0), .score_max(s0), .err(e0));

    card_judge_multi #(.ACE_HIGH(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv01), .card(card),
        .out_valid(ov1), .winner(w1), .bust(b1), .score_max(s1), .err(e1));

    card_judge_multi #(.NUM_PLAYERS(4)) d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .card(card),
        .out_valid(ov2), .winner(w2), .bust(b2), .score_max(s2), .err(e2));

    typedef struct {
        logic [39:0] c;
        int          gap;
        bit          b2b;
        int          w0, b0, s0, e0;
        int          w1, b1, s1, e1;
    } vec_t;

    vec_t v[8];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic send(input logic [79:0] c, input int n, input int gap_after,
                        input int pre_idle, input bit big);
        for (int k = 0; k < pre_idle; k++) begin
            @(negedge clk); iv01 = 1'b0; iv2 = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            card = c[79-4*k -: 4];
            if (big) iv2 = 1'b1; else iv01 = 1'b1;
            if (k == gap_after)
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk); iv01 = 1'b0; iv2 = 1'b0; card = 4'd15;
                end
        end
    endtask

    // Starts right after the last card was driven; walks JUDGE, OUT, verdict.
    task automatic check2(input int i);
        @(negedge clk);
        chk($sformatf("v%0d judge_ov0", i), int'(ov0), 0);
        chk($sformatf("v%0d judge_ov1", i), int'(ov1), 0);
        @(negedge clk);
        chk($sformatf("v%0d out_idle0", i), int'({ov0, w0, b0, s0, e0}), 0);
        chk($sformatf("v%0d out_idle1", i), int'({ov1, w1, b1, s1, e1}), 0);
        @(negedge clk);
        chk($sformatf("v%0d ov0", i), int'(ov0), 1);
        chk($sformatf("v%0d winner0", i), int'(w0), v[i].w0);
        chk($sformatf("v%0d bust0", i), int'(b0), v[i].b0);
        chk($sformatf("v%0d score0", i), int'(s0), v[i].s0);
        chk($sformatf("v%0d err0", i), int'(e0), v[i].e0);
        chk($sformatf("v%0d ov1", i), int'(ov1), 1);
        chk($sformatf("v%0d winner1", i), int'(w1), v[i].w1);
        chk($sformatf("v%0d bust1", i), int'(b1), v[i].b1);
        chk($sformatf("v%0d score1", i), int'(s1), v[i].s1);
        chk($sformatf("v%0d err1", i), int'(e1), v[i].e1);
        @(negedge clk);
        chk($sformatf("v%0d after0", i), int'({ov0, w0, b0, s0, e0}), 0);
        chk($sformatf("v%0d after1", i), int'({ov1, w1, b1, s1, e1}), 0);
    endtask

    task automatic check4(input string nm, input int w, input int b, input int s, input int e);
        @(negedge clk); iv2 = 1'b0;
        chk({nm, " judge_ov"}, int'(ov2), 0);
        @(negedge clk);
        chk({nm, " out_idle"}, int'({ov2, w2, b2, s2, e2}), 0);
        @(negedge clk);
        chk({nm, " ov"}, int'(ov2), 1);
        chk({nm, " winner"}, int'(w2), w);
        chk({nm, " bust"}, int'(b2), b);
        chk({nm, " score"}, int'(s2), s);
        chk({nm, " err"}, int'(e2), e);
        @(negedge clk);
        chk({nm, " after"}, int'({ov2, w2, b2, s2, e2}), 0);
    endtask

    initial begin
        v[0] = '{{4'd2,4'd3,4'd4,4'd5,4'd6,4'd10,4'd13,4'd1,4'd1,4'd1}, -1, 0, 1,2,20,0, 1,2,20,0};
        v[1] = '{{4'd1,4'd2,4'd3,4'd4,4'd10,4'd5,4'd5,4'd5,4'd4,4'd1}, -1, 0, 0,0,20,0, 0,0,20,0};
        v[2] = '{{4'd13,4'd12,4'd11,4'd1,4'd1,4'd10,4'd10,4'd2,4'd1,4'd1}, -1, 0, 0,3,0,0, 0,3,0,0};
        v[3] = '{{4'd1,4'd5,4'd1,4'd2,4'd1,4'd10,4'd10,4'd1,4'd1,4'd1}, -1, 0, 1,2,10,0, 1,2,20,0};
        v[4] = '{{4'd2,4'd3,4'd4,4'd5,4'd6,4'd10,4'd13,4'd1,4'd1,4'd0}, 6, 0, 1,2,20,1, 1,2,20,1};
        v[5] = '{{4'd9,4'd9,4'd1,4'd14,4'd2,4'd7,4'd8,4'd3,4'd1,4'd15}, -1, 1, 1,0,21,1, 1,0,21,1};
        v[6] = '{{4'd10,4'd10,4'd5,4'd0,4'd0,4'd1,4'd1,4'd1,4'd1,4'd1}, -1, 1, 2,1,5,1, 2,1,15,1};
        v[7] = '{{4'd2,4'd3,4'd4,4'd5,4'd6,4'd10,4'd13,4'd1,4'd1,4'd1}, -1, 1, 1,2,20,0, 1,2,20,0};

        repeat (2) @(negedge clk);
        chk("reset d0", int'({ov0, w0, b0, s0, e0}), 0);
        chk("reset d1", int'({ov1, w1, b1, s1, e1}), 0);
        chk("reset d2", int'({ov2, w2, b2, s2, e2}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send({v[i].c, 40'd0}, 10, v[i].gap, v[i].b2b ? 1 : 6, 1'b0);
            fork
                automatic int j = i;
                check2(j);
            join_none
        end
        @(negedge clk); iv01 = 1'b0;
        wait fork;

        // Reset asserted during the verdict cycle must clear outputs at once.
        send({v[0].c, 40'd0}, 10, -1, 2, 1'b0);
        @(negedge clk); iv01 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_async ov0", int'(ov0), 1);
        #1 rst_n = 1'b0;
        #1 chk("async_rst d0", int'({ov0, w0, b0, s0, e0}), 0);
        chk("async_rst d1", int'({ov1, w1, b1, s1, e1}), 0);
        @(negedge clk); rst_n = 1'b1;

        // Four players: partial round then reset mid-round.
        send({{7{4'd10}}, 52'd0}, 7, -1, 2, 1'b1);
        @(negedge clk); iv2 = 1'b0;
        rst_n = 1'b0;
        #1 chk("midrst d2", int'({ov2, w2, b2, s2, e2}), 0);
        @(negedge clk); rst_n = 1'b1;

        send({4'd10,4'd2,4'd2,4'd2,4'd2, 4'd10,4'd5,4'd3,4'd2,4'd1,
              4'd9,4'd9,4'd1,4'd1,4'd1, 4'd5,4'd5,4'd2,4'd2,4'd1}, 20, -1, 2, 1'b1);
        check4("n4 tie", 0, 0, 21, 0);
        send({4'd13,4'd12,4'd1,4'd1,4'd1, 4'd5,4'd5,4'd5,4'd2,4'd2,
              4'd7,4'd7,4'd5,4'd1,4'd1, 4'd10,4'd10,4'd1,4'd1,4'd1}, 20, 5, 2, 1'b1);
        check4("n4 p2win", 3, 9, 21, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
